// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the MIPS pipeline stages and the sequencing controller.
// The pipeline side (master) raises stall requests and exceptions. The controller
// side (slave) answers with the per-stage stall bus, the flush and the redirect PC.
interface pipe_ctrl_if #(
    parameter int STALL_W = 6,
    parameter int CNT_W   = 5
);
    logic               id_stallreq;
    logic               ex_start;
    logic [CNT_W-1:0]   ex_cycles;
    logic               mem_req;
    logic               mem_ack;
    logic               excp_valid;
    logic [31:0]        excp_handler;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [31:0]        new_pc;
    logic               ex_busy;
    logic               mem_timeout;

    modport master (
        output id_stallreq, ex_start, ex_cycles, mem_req, mem_ack,
               excp_valid, excp_handler,
        input  stall, flush, new_pc, ex_busy, mem_timeout
    );

    modport slave (
        input  id_stallreq, ex_start, ex_cycles, mem_req, mem_ack,
               excp_valid, excp_handler,
        output stall, flush, new_pc, ex_busy, mem_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage MIPS core.
// It merges the ID, EX and MEM stall requests into a single prioritised stall
// level, and it runs the EX multi-cycle countdown and the MEM bus-wait watchdog.
// A committed exception overrides everything: it flushes the pipeline and
// redirects the PC.
module pipe_ctrl #(
    parameter int STALL_W     = 6,
    parameter int CNT_W       = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    // Stall levels: a request from stage k holds stage registers 0..k.
    localparam logic [STALL_W-1:0] ID_LVL  = {{(STALL_W-3){1'b0}}, 3'b111};
    localparam logic [STALL_W-1:0] EX_LVL  = {{(STALL_W-4){1'b0}}, 4'b1111};
    localparam logic [STALL_W-1:0] MEM_LVL = {{(STALL_W-5){1'b0}}, 5'b11111};

    typedef enum logic {
        IDLE,
        EX_BUSY
    } ex_state_t;

    ex_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [WCNT_W-1:0] wcnt;

    logic ex_start_ok;
    logic ex_req;
    logic mem_wait;
    logic wd_hit;
    logic mem_stall;

    // Derive the per-stage requests from the inputs and the registered state.
    always_comb begin
        ex_start_ok = bus.ex_start && (bus.ex_cycles != '0);
        ex_req      = (state == IDLE) ? ex_start_ok : (cnt != '0);
        mem_wait    = bus.mem_req && !bus.mem_ack;
        wd_hit      = mem_wait && (wcnt == WCNT_W'(MEM_TIMEOUT));
        mem_stall   = mem_wait && !wd_hit;
    end

    // Output mux: the highest stall level wins, and an exception overrides all of them.
    always_comb begin
        bus.stall       = '0;
        bus.flush       = 1'b0;
        bus.new_pc      = 32'h0;
        bus.ex_busy     = 1'b0;
        bus.mem_timeout = 1'b0;
        if (!rst) begin
            bus.ex_busy = (state == EX_BUSY);
            if (bus.excp_valid) begin
                bus.flush  = 1'b1;
                bus.new_pc = bus.excp_handler;
            end else begin
                bus.mem_timeout = wd_hit;
                if (mem_stall) begin
                    bus.stall = MEM_LVL;
                end else if (ex_req) begin
                    bus.stall = EX_LVL;
                end else if (bus.id_stallreq) begin
                    bus.stall = ID_LVL;
                end
            end
        end
    end

    // EX countdown FSM. It leaves EX_BUSY on the edge where cnt reaches zero, so an op
    // stalls for exactly ex_cycles cycles. ex_start is ignored while the FSM is busy.
    always_ff @(posedge clk) begin
        if (rst || bus.excp_valid) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_start_ok) begin
                        cnt <= bus.ex_cycles - 1'b1;
                        if (bus.ex_cycles > CNT_W'(1)) begin
                            state <= EX_BUSY;
                        end
                    end
                end
                EX_BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // MEM watchdog. It counts consecutive unacknowledged wait cycles and restarts
    // after it fires.
    always_ff @(posedge clk) begin
        if (rst || bus.excp_valid || !mem_wait || wd_hit) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
        end
    end
endmodule
